// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR sequencer types and default widths
// Package fir_pkg: state enum fir_seq_state_t, default sample/coef/accumulator
// widths and FIR_ACC_LAT, the tap datapath pipeline depth shared with the datapath.
package fir_pkg;

    localparam int FIR_NUM_TAPS = 64;
    localparam int FIR_ADDR_W   = 6;
    localparam int FIR_DATA_W   = 24;
    localparam int FIR_COEF_W   = 16;
    localparam int FIR_ACC_W    = 32;
    localparam int FIR_ACC_LAT  = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_RUN     = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_ZERO    = 3'd5
    } fir_seq_state_t;

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// rtl/fir_tap_sequencer_if.sv - sequencer <-> tap datapath / coefficient memory bundle
// master (sequencer): drives coef_addr, tap_en, accum_clr, tap_data, tap_coef;
//                     receives coef_rdata (1-cycle synchronous read) and acc_in.
// slave  (datapath):  the mirror image.
interface fir_tap_sequencer_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 24,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 32
);
    logic [ADDR_W-1:0] coef_addr;
    logic [COEF_W-1:0] coef_rdata;
    logic              tap_en;
    logic              accum_clr;
    logic [DATA_W-1:0] tap_data;
    logic [COEF_W-1:0] tap_coef;
    logic [ACC_W-1:0]  acc_in;

    modport master (
        output coef_addr, tap_en, accum_clr, tap_data, tap_coef,
        input  coef_rdata, acc_in
    );

    modport slave (
        input  coef_addr, tap_en, accum_clr, tap_data, tap_coef,
        output coef_rdata, acc_in
    );
endinterface

// File: rtl/fir_delay_line.sv
// rtl/fir_delay_line.sv - circular sample store, simple dual-port RAM
// Ports: clk; we/waddr/wdata write port; raddr in, rdata out one cycle later.
// No reset and no read-during-write ordering so it maps onto plain RAM.
module fir_delay_line #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/fir_tap_sequencer.sv
// rtl/fir_tap_sequencer.sv - sequences one shared MAC datapath over NUM_TAPS taps per sample
// Ports: clk, reset_n (async active-low); sample_strobe/sample_in new sample;
// dp (master) coefficient address/data, tap_en, accum_clr, tap_data, tap_coef, acc_in;
// audio_out/audio_valid result; busy; overrun sticky flag with overrun_clr.
// Build option FIR_SEQ_ZEROFILL_EN: zero the delay line after every reset.
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int NUM_TAPS = FIR_NUM_TAPS,
    parameter int ADDR_W   = FIR_ADDR_W,
    parameter int DATA_W   = FIR_DATA_W,
    parameter int COEF_W   = FIR_COEF_W,
    parameter int ACC_W    = FIR_ACC_W,
    parameter int ACC_LAT  = FIR_ACC_LAT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sample_strobe,
    input  logic [DATA_W-1:0]      sample_in,
    fir_tap_sequencer_if.master    dp,
    output logic [ACC_W-1:0]       audio_out,
    output logic                   audio_valid,
    output logic                   busy,
    output logic                   overrun,
    input  logic                   overrun_clr
);
    localparam int DRAIN_W = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);
`ifdef FIR_SEQ_ZEROFILL_EN
    localparam fir_seq_state_t RESET_STATE = ST_ZERO;
`else
    localparam fir_seq_state_t RESET_STATE = ST_IDLE;
`endif
    localparam logic RESET_BUSY = (RESET_STATE != ST_IDLE);

    fir_seq_state_t    state_q, state_d;
    logic [ADDR_W-1:0] tap_cnt_q, tap_cnt_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] coef_addr_q, coef_addr_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              tap_en_q, tap_en_d;
    logic              tap0_q, tap0_d;
    logic              accum_clr_q, accum_clr_d;
    logic [DATA_W-1:0] data_hold_q, data_hold_d;
    logic [COEF_W-1:0] coef_hold_q, coef_hold_d;
    logic [ACC_W-1:0]  audio_out_q, audio_out_d;
    logic              audio_valid_q, audio_valid_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] tap_data_live;

    // coef_addr_q is always "next tap index", so the RAM read issued now
    // returns the sample for the tap whose coefficient arrives next cycle.
    assign mem_raddr = wr_ptr_q - coef_addr_q;

    fir_delay_line #(
        .DEPTH  (NUM_TAPS),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_delay_line (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // Tap 0 is written in CLEAR, the same cycle its read would be issued, so
    // it is taken from the captured sample instead of the RAM.
    assign tap_data_live = tap0_q ? sample_q : mem_rdata;

    always_comb begin
        state_d       = state_q;
        tap_cnt_d     = tap_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        wr_ptr_d      = wr_ptr_q;
        coef_addr_d   = coef_addr_q;
        sample_d      = sample_q;
        tap_en_d      = 1'b0;
        tap0_d        = 1'b0;
        accum_clr_d   = 1'b0;
        audio_out_d   = audio_out_q;
        audio_valid_d = 1'b0;
        data_hold_d   = data_hold_q;
        coef_hold_d   = coef_hold_q;
        overrun_d     = overrun_q;
        mem_we        = 1'b0;
        mem_waddr     = wr_ptr_q;
        mem_wdata     = sample_q;

        case (state_q)
            ST_IDLE: begin
                if (sample_strobe) begin
                    state_d     = ST_CLEAR;
                    sample_d    = sample_in;
                    coef_addr_d = '0;
                    accum_clr_d = 1'b1;
                end
            end
            ST_CLEAR: begin
                mem_we      = 1'b1;
                state_d     = ST_RUN;
                tap_cnt_d   = '0;
                coef_addr_d = ADDR_W'(1);
                tap_en_d    = 1'b1;
                tap0_d      = 1'b1;
            end
            ST_RUN: begin
                if (tap_cnt_q == LAST_TAP) begin
                    state_d     = ST_DRAIN;
                    wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
                    drain_cnt_d = DRAIN_W'(ACC_LAT - 1);
                end else begin
                    tap_cnt_d   = tap_cnt_q + ADDR_W'(1);
                    coef_addr_d = coef_addr_q + ADDR_W'(1);
                    tap_en_d    = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                end
            end
            ST_CAPTURE: begin
                state_d       = ST_IDLE;
                audio_out_d   = dp.acc_in;
                audio_valid_d = 1'b1;
            end
            ST_ZERO: begin
                mem_we    = 1'b1;
                mem_waddr = tap_cnt_q;
                mem_wdata = '0;
                if (tap_cnt_q == LAST_TAP) begin
                    state_d   = ST_IDLE;
                    tap_cnt_d = '0;
                end else begin
                    tap_cnt_d = tap_cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Remember what the datapath last saw so the outputs hold between runs.
        if (tap_en_q) begin
            data_hold_d = tap_data_live;
            coef_hold_d = dp.coef_rdata;
        end

        // Set wins over clear so an overrun in the clearing cycle is not lost.
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (sample_strobe && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RESET_STATE;
            tap_cnt_q     <= '0;
            drain_cnt_q   <= '0;
            wr_ptr_q      <= '0;
            coef_addr_q   <= '0;
            sample_q      <= '0;
            tap_en_q      <= 1'b0;
            tap0_q        <= 1'b0;
            accum_clr_q   <= 1'b0;
            data_hold_q   <= '0;
            coef_hold_q   <= '0;
            audio_out_q   <= '0;
            audio_valid_q <= 1'b0;
            busy_q        <= RESET_BUSY;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tap_cnt_q     <= tap_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            coef_addr_q   <= coef_addr_d;
            sample_q      <= sample_d;
            tap_en_q      <= tap_en_d;
            tap0_q        <= tap0_d;
            accum_clr_q   <= accum_clr_d;
            data_hold_q   <= data_hold_d;
            coef_hold_q   <= coef_hold_d;
            audio_out_q   <= audio_out_d;
            audio_valid_q <= audio_valid_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
        end
    end

    assign dp.coef_addr = coef_addr_q;
    assign dp.tap_en    = tap_en_q;
    assign dp.accum_clr = accum_clr_q;
    assign dp.tap_data  = tap_en_q ? tap_data_live : data_hold_q;
    assign dp.tap_coef  = tap_en_q ? dp.coef_rdata : coef_hold_q;
    assign audio_out    = audio_out_q;
    assign audio_valid  = audio_valid_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;
endmodule
